// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard/sequencing controller for a 5-stage pipeline: per-register
//            enable/flush, PC enable, data-memory timeout, halt, perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dren,
    input  logic            mem_dwen,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rt,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            branch_mem,
    input  logic            jump_id,
    input  logic            halt_wb,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            halt_o,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] C_WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic [CNTW-1:0] flush_q, flush_d;

    logic mem_busy, load_use, stall_inc, flush_inc;

    assign mem_busy = (mem_dren | mem_dwen) & ~dhit;
    assign load_use = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halt_o      = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            S_HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halt_o   = 1'b1;
            end
            default: begin
                if (halt_wb) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = S_HALTED;
                end else if (mem_busy) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                    stall_inc   = 1'b1;
                    wait_d      = wait_q + 1'b1;
                    state_d     = S_MEMWAIT;
                    // Counter starts on the first busy cycle (still in RUN),
                    // so the limit is reached on the TIMEOUT-th busy cycle.
                    if (wait_q == C_WAIT_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end
                end else begin
                    wait_d  = '0;
                    state_d = S_RUN;
                    if (branch_mem) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (jump_id) begin
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
            end
        endcase

        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            halt_o      = 1'b0;
        end
    end

    assign stall_d = (stall_inc && (stall_q != {CNTW{1'b1}})) ? stall_q + 1'b1 : stall_q;
    assign flush_d = (flush_inc && (flush_q != {CNTW{1'b1}})) ? flush_q + 1'b1 : flush_q;

    assign mem_err   = err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
`default_nettype wire
